// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller for the 5-stage MIPS pipeline.
// Detects load-use and branch-operand hazards that forwarding cannot cover,
// steers PC / IF/ID / ID/EX hold and clear, and keeps saturating stall and
// flush counters plus a sticky watchdog for runaway stall sequences.
module hazard_stall_unit #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic             uses_rs_D,
    input  logic             uses_rt_D,
    input  logic             Branch_D,
    input  logic             BranchTaken_D,
    input  logic             Jump_D,
    input  logic             MemRead_E,
    input  logic             RegWrite_E,
    input  logic [4:0]       WriteReg_E,
    input  logic             MemRead_M,
    input  logic [4:0]       WriteReg_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             hazard_err
);

    // run_len must be able to hold MAX_STALL itself.
    localparam int              RUN_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_LU_STALL = 2'd1;
    localparam logic [1:0] S_BR_STALL = 2'd2;

    logic [1:0]       r_state;
    logic [RUN_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;
    logic             r_hazard_err;

    logic             w_match_e;
    logic             w_match_m;
    logic             w_lu;
    logic             w_br_e;
    logic             w_br_m;
    logic             w_stall_raw;
    logic             w_stall;
    logic             w_flush;
    logic [1:0]       w_state_nxt;
    logic [RUN_W-1:0] w_run_len_nxt;

    // Register 0 is hardwired, so a write to it can never be a dependency.
    assign w_match_e = (WriteReg_E != 5'd0) &&
                       ((uses_rs_D && (WriteReg_E == rs_D)) ||
                        (uses_rt_D && (WriteReg_E == rt_D)));
    assign w_match_m = (WriteReg_M != 5'd0) &&
                       ((uses_rs_D && (WriteReg_M == rs_D)) ||
                        (uses_rt_D && (WriteReg_M == rt_D)));

    assign w_lu        = MemRead_E & w_match_e;
    assign w_br_e      = Branch_D & RegWrite_E & w_match_e;
    assign w_br_m      = Branch_D & MemRead_M & w_match_m;
    assign w_stall_raw = w_lu | w_br_e | w_br_m;

    // Stall beats flush: while stalled the branch compare sees stale operands.
    assign w_stall = ~RST & w_stall_raw;
    assign w_flush = ~RST & ~w_stall_raw & (Jump_D | (Branch_D & BranchTaken_D));

    assign Stall_F     = w_stall;
    assign Stall_D     = w_stall;
    assign Flush_E     = w_stall;
    assign Flush_D     = w_flush;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
    assign hazard_err  = r_hazard_err;

    // Next-state logic; the state only tracks which kind of stall is in progress.
    always_comb begin
        w_state_nxt = S_RUN;
        case (r_state)
            S_RUN: begin
                if (w_lu)                 w_state_nxt = S_LU_STALL;
                else if (w_br_e | w_br_m) w_state_nxt = S_BR_STALL;
                else                      w_state_nxt = S_RUN;
            end
            S_LU_STALL: begin
                if (w_stall) w_state_nxt = w_br_m ? S_BR_STALL : S_LU_STALL;
                else         w_state_nxt = S_RUN;
            end
            S_BR_STALL: begin
                w_state_nxt = w_stall ? S_BR_STALL : S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Consecutive stall length, saturating at MAX_STALL.
    always_comb begin
        w_run_len_nxt = '0;
        if (w_stall) begin
            w_run_len_nxt = (r_run_len >= RUN_MAX) ? RUN_MAX : (r_run_len + RUN_W'(1));
        end
    end

    // State, watchdog and saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_RUN;
            r_run_len     <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
            r_hazard_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_len <= w_run_len_nxt;
            // The stall that brings the run to MAX_STALL trips the watchdog.
            if (w_stall && (w_run_len_nxt == RUN_MAX)) begin
                r_hazard_err <= 1'b1;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

- Decode-stage hazard controller for the 5-stage MIPS pipeline.
- Decides when the pipeline must stall or flush: load-use hazards, branch operands not yet available in ID, and taken-branch/jump flushes.
- Works alongside the EX-stage forwarding logic. It covers the dependencies forwarding cannot resolve, and it steers the PC, IF/ID and ID/EX pipeline registers.
- Keeps a small state machine plus saturating performance counters and a stall watchdog.

## Interface

Parameters:
- CNT_W, 16, width of the stall and flush counters.
- MAX_STALL, 4, number of consecutive stall cycles after which hazard_err is set.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- rs_D  input  5  ID-stage rs field.
- rt_D  input  5  ID-stage rt field.
- uses_rs_D  input  1  ID instruction reads rs.
- uses_rt_D  input  1  ID instruction reads rt.
- Branch_D  input  1  ID instruction is beq/bne (compared in ID).
- BranchTaken_D  input  1  ID comparator result, valid when Branch_D=1.
- Jump_D  input  1  ID instruction is j/jal/jr.
- MemRead_E  input  1  EX instruction is a load.
- RegWrite_E  input  1  EX instruction writes a register.
- WriteReg_E  input  5  EX destination register.
- MemRead_M  input  1  MEM instruction is a load.
- WriteReg_M  input  5  MEM destination register.
- Stall_F  output  1  hold the PC.
- Stall_D  output  1  hold IF/ID.
- Flush_D  output  1  clear IF/ID (squash the fetched instruction).
- Flush_E  output  1  clear ID/EX (insert a bubble).
- stall_count  output  CNT_W  total stall cycles since reset; saturating.
- flush_count  output  CNT_W  total Flush_D cycles since reset; saturating.
- hazard_err  output  1  sticky watchdog flag.

## Operation

Match terms:
- match_rs(r): uses_rs_D and r != 0 and r == rs_D.
- match_rt(r): uses_rt_D and r != 0 and r == rt_D.
- match(r): match_rs(r) or match_rt(r).

Hazard conditions:
- lu: MemRead_E and match(WriteReg_E). Load-use hazard.
- br_e: Branch_D and RegWrite_E and match(WriteReg_E). The ALU result is not ready for the ID compare.
- br_m: Branch_D and MemRead_M and match(WriteReg_M). The load data is not ready for the ID compare.
- stall = lu or br_e or br_m.

Outputs (combinational, Mealy):
- Stall_F = Stall_D = Flush_E = stall.
- Flush_D = not stall and (Jump_D or (Branch_D and BranchTaken_D)).
- A stall always has priority over a flush. BranchTaken_D is ignored while stalling because its operands are stale.
- While RST=1, all four control outputs are forced to 0.

State machine (state register, encoding is implementer's choice):
- RUN: no stall last cycle.
  - lu → LU_STALL.
  - br_e or br_m → BR_STALL.
  - Otherwise stay in RUN.
- LU_STALL:
  - stall → BR_STALL if br_m, else LU_STALL.
  - No stall → RUN.
- BR_STALL:
  - stall → BR_STALL.
  - No stall → RUN.
- State is informational for the watchdog and debug; outputs do not depend on it.

Counters and watchdog:
- run_len: consecutive stall cycles. Increments while stall=1 and resets to 0 when stall=0; saturates at MAX_STALL.
- hazard_err is set when run_len == MAX_STALL and stall=1. It stays set until RST.
- stall_count increments on every cycle with stall=1.
- flush_count increments on every cycle with Flush_D=1.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing

- Control outputs are combinational, valid within the same cycle as their inputs. Zero latency.
- Counters, run_len, state and hazard_err update on the rising CLK edge following the qualifying cycle.
- Reset values (after a rising edge with RST=1): state=RUN, run_len=0, stall_count=0, flush_count=0, hazard_err=0.
- RST asserted mid-stall: the outputs drop in that cycle, and all state clears at the edge. The first cycle after reset re-evaluates hazards from scratch.
- Load directly followed by a dependent branch: 2 stall cycles (lu, then br_m). state goes RUN→LU_STALL→BR_STALL→RUN.
- ALU op directly followed by a dependent branch: 1 stall cycle (br_e).
- Writes to register 0 never cause a stall.
- Simultaneous lu and Jump_D: stall wins and Flush_D=0. The flush is issued on the first non-stall cycle.
- Counter saturation: at 2^CNT_W−1, a further qualifying event leaves the value unchanged.

## Test plan

- lw $8 in EX (MemRead_E=1, WriteReg_E=8), ID add with rs_D=8, uses_rs_D=1 → Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle, Flush_D=0, then stall_count=1.
- lw $9 followed by beq $9,$0 → stall for 2 consecutive cycles (br_m in the second), then BranchTaken_D=1 → Flush_D=1 for 1 cycle. Afterwards stall_count=2 and flush_count=1.
- WriteReg_E=0 with MemRead_E=1 and rs_D=0 → no stall. Separately, Jump_D=1 with no hazard → Flush_D=1 and flush_count increments by 1.
- lu and Jump_D in the same cycle → Flush_D=0 and stall=1. The next cycle, with the hazard gone → Flush_D=1.
- MAX_STALL=4, hold the lu condition for 4 cycles → hazard_err=1 after the 4th edge and stays 1 after the hazard clears. Then RST=1 for 1 cycle → hazard_err, counters and state are all 0.
- CNT_W=4, hold the stall condition for 20 cycles (with MAX_STALL large) → stall_count saturates at 15. RST asserted mid-stall → outputs are 0 in that cycle and counters are 0 after the edge.
